// File: rtl/test_port_pkg.sv
// Shared constants, state encoding and byte-order helper for the test-port result writer.
package test_port_pkg;

    localparam logic [29:0] TEST_PORT = 30'hFF;
    localparam logic [31:0] BEGIN_SYM = 32'h00000168;
    localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BEGIN   = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_GAP     = 3'd3,
        ST_END     = 3'd4,
        ST_DONE    = 3'd5
    } tpw_state_t;

    // Readable (big-endian) word to the little-endian order the bus expects.
    function automatic logic [31:0] byteswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/test_port_writer_fifo.sv
// tpw_fifo: DEPTH x WIDTH synchronous FIFO with flush; head is visible combinationally,
// so a pushed word becomes poppable only on the cycle after its push.
module tpw_fifo
    import test_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign head      = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/test_port_writer.sv
// test_port_writer: emits BEGIN_SYM, NUM_WORDS buffered payload words and END_SYM as bus writes.
// Optional idle timeout in PAYLOAD is enabled by defining TPW_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start, FIFO may fill
// BEGIN   | BEGIN_SYM write presented until accepted
// PAYLOAD | wait for FIFO data, pop and present one payload write
// GAP     | mandatory wen=0 cycle after every accepted write
// END     | END_SYM write presented until accepted
// DONE    | run complete, done=1, FIFO input closed
module test_port_writer
    import test_port_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_WORDS = 31,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        mem_stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [6:0]  words_sent,
    output logic        err
);

    tpw_state_t  r_state;
    logic        r_wen;
    logic [29:0] r_addr;
    logic [31:0] r_data;
    logic        r_done;
    logic [6:0]  r_words_sent;
    logic [6:0]  r_pay_cnt;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_accept;
    logic        w_timeout;
    logic [31:0] w_head;

    assign w_accept = r_wen & ~mem_stall;
    assign in_ready = ~w_full & (r_state != ST_DONE);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == ST_PAYLOAD) & ~r_wen & ~w_empty;
    // Leftover payload from an over-long stream is discarded when the next run starts.
    assign w_flush  = (r_state == ST_DONE) & start;

    tpw_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

`ifdef TPW_TIMEOUT_EN
    localparam logic [15:0] IDLE_LOAD = 16'(TIMEOUT - 1);

    logic [15:0] r_idle_cnt;
    logic        r_err;
    logic        w_idle;

    assign w_idle    = (r_state == ST_PAYLOAD) & ~r_wen & w_empty;
    assign w_timeout = w_idle & (r_idle_cnt == 16'd0);
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= IDLE_LOAD;
            r_err      <= 1'b0;
        end else begin
            if (w_idle && r_idle_cnt != 16'd0) r_idle_cnt <= r_idle_cnt - 16'd1;
            else                               r_idle_cnt <= IDLE_LOAD;
            if (start && (r_state == ST_IDLE || r_state == ST_DONE)) r_err <= 1'b0;
            else if (w_timeout)                                      r_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_done       <= 1'b0;
            r_words_sent <= '0;
            r_pay_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_wen        <= 1'b0;
                r_addr       <= '0;
                r_data       <= '0;
                r_words_sent <= r_words_sent + 7'd1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_BEGIN;
                        r_done       <= 1'b0;
                        r_words_sent <= '0;
                        r_pay_cnt    <= '0;
                        r_wen        <= 1'b1;
                        r_addr       <= TEST_PORT;
                        r_data       <= byteswap32(BEGIN_SYM);
                    end
                end
                ST_BEGIN: begin
                    if (w_accept) r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_pay_cnt < 7'(NUM_WORDS)) begin
                        r_state <= ST_PAYLOAD;
                    end else begin
                        r_state <= ST_END;
                        r_wen   <= 1'b1;
                        r_addr  <= TEST_PORT;
                        r_data  <= byteswap32(END_SYM);
                    end
                end
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        r_state   <= ST_GAP;
                        r_pay_cnt <= r_pay_cnt + 7'd1;
                    end else if (w_pop) begin
                        r_wen  <= 1'b1;
                        r_addr <= TEST_PORT;
                        r_data <= byteswap32(w_head);
                    end else if (w_timeout) begin
                        r_state <= ST_END;
                        r_wen   <= 1'b1;
                        r_addr  <= TEST_PORT;
                        r_data  <= byteswap32(END_SYM);
                    end
                end
                ST_END: begin
                    if (w_accept) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wen        = r_wen;
    assign addr       = r_addr;
    assign data       = r_data;
    assign done       = r_done;
    assign words_sent = r_words_sent;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_test_port_writer.sv
// Scoreboard bench for test_port_writer: stimulus feeds a payload queue, a negedge monitor
// checks every accepted bus write against the expected BEGIN / payload / END sequence.
module tb_test_port_writer;

    localparam int NW = 31;
    localparam logic [31:0] SYM_BEGIN = 32'h00000168;
    localparam logic [31:0] SYM_END   = 32'hFFFFFD5D;
    localparam logic [29:0] PORT_ADDR = 30'hFF;
`ifdef TPW_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int WAIT_CYC = 10;
`else
    localparam bit TO_EN = 1'b0;
    localparam int WAIT_CYC = 20;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        mem_stall = 1'b0;
    logic        in_ready;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        busy;
    logic        done;
    logic [6:0]  words_sent;
    logic        err;

    test_port_writer #(.DEPTH(4), .NUM_WORDS(NW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_stall(mem_stall), .addr(addr), .data(data), .wen(wen),
        .busy(busy), .done(done), .words_sent(words_sent), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    logic [31:0] mdl_q [$];
    bit          mdl_running = 0, mdl_done = 0;
    int          mon_k = 0, mon_pay = 0, exp_ws = 0;
    bit          prev_acc = 0, prev_stall = 0;
    logic [29:0] prev_addr;
    logic [31:0] prev_data;
    int          zero_run = 0, last_gap = 0, stall3_cnt = 0;
    bit          force_stall3 = 0, stall_rand = 0;
    logic [31:0] first_data = '0, last_data = '0;
    logic [31:0] e_word;
    bit          e_valid, e_end;

    function automatic logic [31:0] le(input logic [31:0] w);
        return ((w & 32'hFF) << 24) | (((w >> 8) & 32'hFF) << 16) |
               (((w >> 16) & 32'hFF) << 8) | ((w >> 24) & 32'hFF);
    endfunction

    function automatic int fib(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor and reference sequence.
    always @(negedge clk) begin
        if (rst) begin
            mdl_q.delete();
            mdl_running = 0; mdl_done = 0;
            mon_k = 0; mon_pay = 0; exp_ws = 0;
            prev_acc = 0; prev_stall = 0; zero_run = 0;
        end else begin
            chk("words_sent", 32'(words_sent), 32'(exp_ws));
            chk("busy", 32'(busy), 32'(mdl_running));
            chk("done", 32'(done), 32'(mdl_done));
            if (!TO_EN) chk("err_zero", 32'(err), 32'd0);
            if (mdl_done) chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (!wen) chk("addr_when_idle", 32'(addr), 32'd0);
            if (prev_acc) chk("gap_after_write", 32'(wen), 32'd0);
            if (prev_stall) begin
                chk("stall_hold_wen", 32'(wen), 32'd1);
                chk("stall_hold_addr", 32'(addr), 32'(prev_addr));
                chk("stall_hold_data", data, prev_data);
            end
            if (wen && mem_stall && mon_k == 2) stall3_cnt++;
            if (wen) begin
                if (zero_run > 0) last_gap = zero_run;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            if (wen && !mem_stall) begin
                e_valid = 1; e_end = 0;
                if (mon_k == 0) begin
                    e_word = le(SYM_BEGIN);
                    first_data = data;
                end else if (mon_pay < NW && mdl_q.size() > 0) begin
                    e_word = le(mdl_q.pop_front());
                    mon_pay++;
                end else if (mon_pay == NW || TO_EN) begin
                    e_word = le(SYM_END);
                    e_end = 1;
                end else begin
                    chk("payload_available", 32'(mdl_q.size()), 32'd1);
                    e_valid = 0;
                end
                if (e_valid) chk("write_data", data, e_word);
                chk("write_addr", 32'(addr), 32'(PORT_ADDR));
                if (e_end) begin
                    last_data = data;
                    mdl_done = 1; mdl_running = 0;
                end
                exp_ws++; mon_k++;
            end
            prev_acc = wen && !mem_stall;
            prev_stall = wen && mem_stall;
            prev_addr = addr; prev_data = data;
            if (start && !mdl_running) begin
                if (mdl_done) mdl_q.delete();
                mdl_running = 1; mdl_done = 0;
                mon_k = 0; mon_pay = 0; exp_ws = 0;
            end
        end
    end

    // Bus stall driver.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (force_stall3 && wen && mon_k == 2) begin
                for (int i = 0; i < 5; i++) begin
                    mem_stall = 1'b1;
                    @(posedge clk); #1;
                end
                mem_stall = 1'b0;
                force_stall3 = 0;
            end else begin
                mem_stall = stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        bit ok = 0;
        in_valid = 1'b1; in_data = w;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (ok) mdl_q.push_back(w);
        else chk("push_accepted", 32'd0, 32'd1);
    endtask

    task automatic push_fib();
        for (int i = 0; i < NW; i++) push_word(32'(fib(i < 16 ? i : 31 - i)));
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_word($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int t = 0; t < 3000 && !mdl_done; t++) @(negedge clk);
        chk(name, 32'(mdl_done), 32'd1);
        @(negedge clk);
        chk({name, "_done_out"}, 32'(done), 32'd1);
    endtask

    task automatic wait_pay(input int n);
        for (int t = 0; t < 3000 && mon_pay < n; t++) @(negedge clk);
        chk("payload_progress", 32'(mon_pay >= n), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words_sent", 32'(words_sent), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Fibonacci run, start while payload is still streaming in.
        fork
            push_fib();
            begin repeat (6) @(posedge clk); #1; pulse_start(); end
        join
        wait_done("fib_run");
        chk("fib_first_data", first_data, 32'h68010000);
        chk("fib_last_data", last_data, 32'h5DFDFFFF);
        chk("fib_words_sent", 32'(words_sent), 32'd33);
        @(posedge clk); #1;

        // Random stalls plus a forced 5-cycle stall on the third write.
        stall_rand = 1; force_stall3 = 1; stall3_cnt = 0;
        pulse_start();
        push_rand(NW);
        wait_done("stall_run");
        stall_rand = 0;
        chk("stall3_cycles", 32'(stall3_cnt), 32'd5);
        chk("stall_words_sent", 32'(words_sent), 32'd33);
        @(posedge clk); #1;

        // Fill the FIFO in IDLE; words offered while full are dropped.
        do_reset();
        push_rand(4);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        fork
            pulse_start();
            push_rand(NW - 4);
        join
        wait_done("full_run");
        @(posedge clk); #1;

        // Payload arrives long after start.
        pulse_start();
        for (int t = 0; t < 200 && mon_k < 1; t++) @(negedge clk);
        chk("late_begin_seen", 32'(mon_k), 32'd1);
        for (int t = 0; t < WAIT_CYC; t++) begin
            @(negedge clk);
            chk("late_wait_wen", 32'(wen), 32'd0);
        end
        @(posedge clk); #1;
        push_rand(NW);
        wait_done("late_run");
        @(posedge clk); #1;

        // Abort mid-run, then a clean run from IDLE.
        fork
            pulse_start();
            push_rand(12);
        join
        wait_pay(10);
        do_reset();
        @(negedge clk);
        chk("abort_wen", 32'(wen), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_words_sent", 32'(words_sent), 32'd0);
        @(posedge clk); #1;
        fork
            pulse_start();
            push_rand(NW);
        join
        wait_done("after_abort_run");
        chk("after_abort_words_sent", 32'(words_sent), 32'd33);
        @(posedge clk); #1;

`ifdef TPW_TIMEOUT_EN
        // Short payload: the idle limit forces the END write.
        do_reset();
        push_rand(3);
        pulse_start();
        wait_done("timeout_run");
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_words_sent", 32'(words_sent), 32'd5);
        chk("timeout_idle_gap", 32'(last_gap), 32'd17);
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
